s_axis_pingpong_ram_wr: RTL

Parametrised AXI4-Stream slave that writes each incoming frame into one half of an external double-banked simple-dual-port RAM. It generalises the single-bank stream-to-RAM writer with configurable data/address width, byte strobes from TKEEP, ping-pong banking with consumer release, backpressure when both banks are full, and overflow drop. It also reports per-frame status (length, overflow, cycle count). It sits between the DMA MM2S stream and the PL RAM consumer.

---
 rtl/s_axis_ram_wr_pkg.sv | 16 +
 rtl/s_axis_bank_tracker.sv | 30 +++
 rtl/s_axis_pingpong_ram_wr.sv | 126 ++++++++++++
 3 files changed

// File: rtl/s_axis_ram_wr_pkg.sv
// Shared state encoding and constants for the ping-pong stream-to-RAM writer.
package s_axis_ram_wr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RECV  = 4'd1,
    ST_DRAIN = 4'd2
  } wr_state_t;

  localparam logic [15:0] CYC_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CYC_SAT) ? CYC_SAT : v + 16'd1;
  endfunction

endpackage

// File: rtl/s_axis_bank_tracker.sv
// Tracks which of the two RAM banks hold an unconsumed frame and which bank
// the next frame is written into.
module s_axis_bank_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       commit,
  input  logic       rel,
  input  logic       rel_sel,
  output logic [1:0] bank_full,
  output logic       wr_bank
);

  // A commit and a release on the same bank: the new frame must not be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wr_bank == 1'(b)))
          bank_full[b] <= 1'b1;
        else if (rel && (rel_sel == 1'(b)))
          bank_full[b] <= 1'b0;
      end
      if (commit)
        wr_bank <= ~wr_bank;
    end
  end

endmodule

// File: rtl/s_axis_pingpong_ram_wr.sv
// AXI4-Stream slave writing each frame into one half of a double-banked RAM,
// with consumer-released ping-pong banking, overflow drop and per-frame status.
module s_axis_pingpong_ram_wr
  import s_axis_ram_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                S_AXIS_ACLK,
  input  logic                S_AXIS_ARESET,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TLAST,
  output logic                RAM_WEN,
  output logic [ADDR_W:0]     RAM_WADDR,
  output logic [DATA_W-1:0]   RAM_WDATA,
  output logic [DATA_W/8-1:0] RAM_WSTRB,
  input  logic                BANK_RELEASE,
  input  logic                BANK_RELEASE_SEL,
  output logic                FRAME_DONE,
  output logic                FRAME_BANK,
  output logic [ADDR_W:0]     FRAME_LEN,
  output logic                FRAME_OVF,
  output logic [15:0]         FRAME_CYCLES,
  output logic [31:0]         debug_state
);

  localparam int              KEEP_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  wr_state_t       state;
  logic [ADDR_W:0] beat_cnt;
  logic [ADDR_W:0] beat_inc;
  logic            ovf;
  logic [15:0]     cyc_cnt;
  logic [15:0]     cyc_now;
  logic            accept;
  logic            commit;
  logic [1:0]      bank_full;
  logic            wr_bank;

  assign S_AXIS_TREADY = (state != ST_IDLE);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign commit        = accept && S_AXIS_TLAST;
  assign beat_inc      = beat_cnt + ONE;
  assign cyc_now       = sat_inc16(cyc_cnt);

  s_axis_bank_tracker u_banks (
    .clk       (S_AXIS_ACLK),
    .rst       (S_AXIS_ARESET),
    .commit    (commit),
    .rel       (BANK_RELEASE),
    .rel_sel   (BANK_RELEASE_SEL),
    .bank_full (bank_full),
    .wr_bank   (wr_bank)
  );

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      ovf          <= 1'b0;
      cyc_cnt      <= '0;
      RAM_WEN      <= 1'b0;
      RAM_WADDR    <= '0;
      RAM_WDATA    <= '0;
      RAM_WSTRB    <= '0;
      FRAME_DONE   <= 1'b0;
      FRAME_BANK   <= 1'b0;
      FRAME_LEN    <= '0;
      FRAME_OVF    <= 1'b0;
      FRAME_CYCLES <= '0;
    end else begin
      RAM_WEN    <= 1'b0;
      RAM_WADDR  <= '0;
      RAM_WDATA  <= '0;
      RAM_WSTRB  <= '0;
      FRAME_DONE <= 1'b0;

      // The cycle counter starts on the first accepted beat and then free-runs.
      if (accept || (cyc_cnt != 16'd0))
        cyc_cnt <= cyc_now;

      case (state)
        ST_IDLE: begin
          if (!bank_full[wr_bank])
            state <= ST_RECV;
        end
        ST_RECV: begin
          if (accept) begin
            RAM_WEN   <= 1'b1;
            RAM_WADDR <= {wr_bank, beat_cnt[ADDR_W-1:0]};
            RAM_WDATA <= S_AXIS_TDATA;
            RAM_WSTRB <= S_AXIS_TKEEP[KEEP_W-1:0];
            beat_cnt  <= beat_inc;
            if (!S_AXIS_TLAST && (beat_cnt == LAST_IDX))
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (accept)
            ovf <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        FRAME_DONE   <= 1'b1;
        FRAME_BANK   <= wr_bank;
        FRAME_LEN    <= (state == ST_RECV) ? beat_inc : beat_cnt;
        FRAME_OVF    <= ovf || (state == ST_DRAIN);
        FRAME_CYCLES <= cyc_now;
        state        <= ST_IDLE;
        beat_cnt     <= '0;
        ovf          <= 1'b0;
        cyc_cnt      <= '0;
      end
    end
  end

  assign debug_state = {state, bank_full, wr_bank, 9'd0, FRAME_CYCLES};

endmodule
